// File: rtl/updown_counter_param.sv
// updown_counter_param
// Parametrised synchronous up/down counter with programmable modulus,
// wrap or saturate at the ends of the range, parallel load with clipping,
// count enable, a combinational terminal-count flag and a registered
// one-cycle overflow/underflow pulse.
module updown_counter_param #(
  parameter int unsigned         WIDTH    = 4,
  parameter logic [WIDTH-1:0]    MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]    RST_VAL  = '0,
  parameter bit                  SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             atMax;
  logic             atZero;

  // End-of-range decode; tc follows the live direction input, not en
  always_comb begin
    atMax  = (count_q == MAX_VAL);
    atZero = (count_q == '0);
    tc     = (up & atMax) | (~up & atZero);
  end

  // Next-state selection: load beats count enable, and the explicit end
  // compares keep a non-power-of-two modulus inside 0..MAX_VAL
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (load) begin
      count_d = (din > MAX_VAL) ? MAX_VAL : din;
    end else if (en) begin
      ovf_d = tc;
      if (up) begin
        if (atMax) begin
          count_d = SATURATE ? MAX_VAL : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (atZero) begin
          count_d = SATURATE ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State register; synchronous reset overrides load and enable
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_VAL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;
  assign zero  = atZero;

endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param
// Directed bench driving two counter instances from shared inputs:
// devA is a decade counter (MAX_VAL 9, reset to 9, wrapping) and devB is
// a full-range 4-bit saturating counter reset to 0.
module tb_updown_counter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] din;

  logic [3:0] countA;
  logic       tcA;
  logic       ovfA;
  logic       zeroA;
  logic [3:0] countB;
  logic       tcB;
  logic       ovfB;
  logic       zeroB;

  int checks;
  int errors;

  updown_counter_param #(
    .WIDTH(4), .MAX_VAL(4'd9), .RST_VAL(4'd9), .SATURATE(1'b0)
  ) devA (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(countA), .tc(tcA), .ovf(ovfA), .zero(zeroA)
  );

  updown_counter_param #(
    .WIDTH(4), .SATURATE(1'b1)
  ) devB (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .count(countB), .tc(tcB), .ovf(ovfB), .zero(zeroB)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set every shared input for the next edge
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [3:0] d);
    rst  = r;
    en   = e;
    up   = u;
    load = l;
    din  = d;
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  logic [3:0] downSeq [12] = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3,
                               4'd2, 4'd1, 4'd0, 4'd9, 4'd8, 4'd7};
  logic       downOvf [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] satSeqB [5]  = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
  logic       satOvfB [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] upSeqA  [5]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
  logic       upOvfA  [5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    checks = 0;
    errors = 0;

    // Reset for two edges, then hold with en low
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("rst countA", countA, 9);
      checkOutput("rst ovfA",   ovfA,   0);
      checkOutput("rst zeroA",  zeroA,  0);
      checkOutput("rst countB", countB, 0);
      checkOutput("rst zeroB",  zeroB,  1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold countA", countA, 9);
      checkOutput("hold ovfA",   ovfA,   0);
      checkOutput("hold zeroA",  zeroA,  0);
    end

    // Decade down-count with wrap on devA; devB sits at 0 saturated
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      checkOutput("down countA", countA, downSeq[i]);
      checkOutput("down ovfA",   ovfA,   downOvf[i]);
      checkOutput("down tcA",    tcA,    downSeq[i] == 4'd0);
      checkOutput("down zeroA",  zeroA,  downSeq[i] == 4'd0);
    end
    checkOutput("downsat countB", countB, 0);
    checkOutput("downsat ovfB",   ovfB,   1);

    // Load 13: devB takes it, devA clips to 9, pending ovf is cleared
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd13);
    step();
    checkOutput("clip countA", countA, 9);
    checkOutput("load countB", countB, 13);
    checkOutput("load ovfB",   ovfB,   0);

    // Up-count: devB saturates at 15, devA wraps 9 -> 0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("sat countB", countB, satSeqB[i]);
      checkOutput("sat ovfB",   ovfB,   satOvfB[i]);
      checkOutput("upwrap countA", countA, upSeqA[i]);
      checkOutput("upwrap ovfA",   ovfA,   upOvfA[i]);
    end
    checkOutput("sat tcB", tcB, 1);

    // Load beats en
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    step();
    checkOutput("loadprio countA", countA, 3);
    checkOutput("loadprio ovfA",   ovfA,   0);

    // Load coincident with terminal count and en
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    #1;
    checkOutput("loadtc tcA", tcA, 1);
    step();
    checkOutput("loadtc countA", countA, 2);
    checkOutput("loadtc ovfA",   ovfA,   0);

    // Reset beats load
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    step();
    checkOutput("rstprio countA", countA, 9);
    checkOutput("rstprio countB", countB, 0);
    checkOutput("rstprio ovfA",   ovfA,   0);

    // Direction flip at the top boundary
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    checkOutput("flip tc up", tcA, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    checkOutput("flip tc down", tcA, 0);
    step();
    checkOutput("flip countA", countA, 8);
    checkOutput("flip ovfA",   ovfA,   0);

    // Reset on the edge where a wrap would occur
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    checkOutput("pre-rst countA", countA, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    checkOutput("midrst tcA", tcA, 1);
    step();
    checkOutput("midrst countA", countA, 9);
    checkOutput("midrst ovfA",   ovfA,   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    checkOutput("postrst countA", countA, 9);
    checkOutput("postrst ovfA",   ovfA,   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
